// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite address decoder, data-phase response mux and two-cycle ERROR default slave.
// Also records unmapped NONSEQ/SEQ accesses: last address, saturating count and a one-cycle IRQ.
module ahb_lite_decode_mux #(
   parameter int                  NPORT   = 8,
   parameter logic [NPORT-1:0]    PORT_EN = {NPORT{1'b1}},
   parameter logic [NPORT*32-1:0] BASE    = {NPORT{32'h0}},
   parameter logic [NPORT*32-1:0] MASK    = {NPORT{32'hFFFF_0000}},
   parameter int                  CNT_W   = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   output logic [NPORT-1:0]      S_HSEL,
   input  logic [NPORT*32-1:0]   S_HRDATA,
   input  logic [NPORT-1:0]      S_HREADYOUT,
   input  logic [NPORT-1:0]      S_HRESP,
   output logic [31:0]           HRDATA,
   output logic                  HREADY,
   output logic                  HRESP,
   output logic [31:0]           FAULT_ADDR,
   output logic [CNT_W-1:0]      FAULT_CNT,
   output logic                  FAULT_IRQ
);

   // Data-phase select encoding: 0..NPORT-1 = slave port, then DEFAULT, then NONE.
   localparam int               SEL_W       = $clog2(NPORT + 2);
   localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(NPORT);
   localparam logic [SEL_W-1:0] SEL_NONE    = SEL_W'(NPORT + 1);

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   logic [NPORT-1:0] hit;
   logic             any_hit;
   logic [SEL_W-1:0] dsel_d;
   logic [SEL_W-1:0] dsel_q;
   logic             xfer_active;
   logic             fault_cond;

   ds_state_e        ds_state_q;
   logic             ds_hready_q;
   logic             ds_hresp_q;

   logic [31:0]      fault_addr_q;
   logic [CNT_W-1:0] fault_cnt_q;
   logic             fault_irq_q;

   always_comb begin : address_decode
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      hit     = '0;
      S_HSEL  = '0;
      any_hit = 1'b0;
      dsel_d  = SEL_DEFAULT;
      for (int i = 0; i < NPORT; i++) begin
         hit[i] = PORT_EN[i] && ((HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32]);
         if (hit[i] && !any_hit) begin
            S_HSEL[i] = 1'b1;
            dsel_d    = SEL_W'(i);
            any_hit   = 1'b1;
         end
      end
   end

   assign xfer_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
   assign fault_cond  = HREADY && !any_hit && xfer_active;

   always_comb begin : response_mux
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dsel_q == SEL_DEFAULT) begin
         HREADY = ds_hready_q;
         HRESP  = ds_hresp_q;
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            if (dsel_q == SEL_W'(i)) begin
               HRDATA = S_HRDATA[32*i +: 32];
               HREADY = S_HREADYOUT[i];
               HRESP  = S_HRESP[i];
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin : data_phase_select
      // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
      if (HRESET) begin
         dsel_q <= SEL_NONE;
      end else if (HREADY) begin
         dsel_q <= dsel_d;
      end
   end

   // Default slave: ERR1 stalls with ERROR, ERR2 completes the ERROR response.
   always_ff @(posedge HCLK) begin : default_slave
      if (HRESET) begin
         ds_state_q  <= DS_IDLE;
         ds_hready_q <= 1'b1;
         ds_hresp_q  <= 1'b0;
      end else begin
         case (ds_state_q)
            DS_IDLE: begin
               if (fault_cond) begin
                  ds_state_q  <= DS_ERR1;
                  ds_hready_q <= 1'b0;
                  ds_hresp_q  <= 1'b1;
               end
            end
            DS_ERR1: begin
               ds_state_q  <= DS_ERR2;
               ds_hready_q <= 1'b1;
               ds_hresp_q  <= 1'b1;
            end
            DS_ERR2: begin
               if (fault_cond) begin
                  ds_state_q  <= DS_ERR1;
                  ds_hready_q <= 1'b0;
                  ds_hresp_q  <= 1'b1;
               end else begin
                  ds_state_q  <= DS_IDLE;
                  ds_hready_q <= 1'b1;
                  ds_hresp_q  <= 1'b0;
               end
            end
            default: begin
               ds_state_q  <= DS_IDLE;
               ds_hready_q <= 1'b1;
               ds_hresp_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin : fault_capture
      if (HRESET) begin
         fault_addr_q <= '0;
         fault_cnt_q  <= '0;
         fault_irq_q  <= 1'b0;
      end else begin
         fault_irq_q <= fault_cond;
         if (fault_cond) begin
            fault_addr_q <= HADDR;
            if (fault_cnt_q != {CNT_W{1'b1}}) begin
               fault_cnt_q <= fault_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign FAULT_ADDR = fault_addr_q;
   assign FAULT_CNT  = fault_cnt_q;
   assign FAULT_IRQ  = fault_irq_q;

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// Bench for ahb_lite_decode_mux: a decode/data-phase vector table fed through a scoreboard,
// plus hand-written sequences for wait states, ERROR pairs, reset in ERR1 and counter saturation.
module tb_ahb_lite_decode_mux;

   localparam logic [255:0] MAP_BASE = {32'h9000_0000, 32'h8000_0000, 32'h5000_0000, 32'h4000_0000,
                                        32'h3000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic         hclk;
   logic         hreset;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic [255:0] s_hrdata;
   logic [7:0]   s_hreadyout;
   logic [7:0]   s_hresp;

   logic [7:0]   m_hsel,  e_hsel,  s_hsel;
   logic [31:0]  m_hrdata, e_hrdata, s_hrdata_o;
   logic         m_hready, e_hready, s_hready;
   logic         m_hresp,  e_hresp,  s_hresp_o;
   logic [31:0]  m_faddr,  e_faddr,  s_faddr;
   logic [7:0]   m_fcnt,   e_fcnt;
   logic [1:0]   s_fcnt;
   logic         m_firq,   e_firq,   s_firq;

   ahb_lite_decode_mux #(.NPORT(8), .PORT_EN(8'hFF), .BASE(MAP_BASE), .CNT_W(8)) u_main (
      .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .S_HSEL(m_hsel),
      .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
      .HRDATA(m_hrdata), .HREADY(m_hready), .HRESP(m_hresp),
      .FAULT_ADDR(m_faddr), .FAULT_CNT(m_fcnt), .FAULT_IRQ(m_firq));

   ahb_lite_decode_mux #(.NPORT(8), .PORT_EN(8'hFB), .BASE(MAP_BASE), .CNT_W(8)) u_en (
      .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .S_HSEL(e_hsel),
      .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
      .HRDATA(e_hrdata), .HREADY(e_hready), .HRESP(e_hresp),
      .FAULT_ADDR(e_faddr), .FAULT_CNT(e_fcnt), .FAULT_IRQ(e_firq));

   ahb_lite_decode_mux #(.NPORT(8), .PORT_EN(8'hFF), .BASE(MAP_BASE), .CNT_W(2)) u_sat (
      .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .S_HSEL(s_hsel),
      .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
      .HRDATA(s_hrdata_o), .HREADY(s_hready), .HRESP(s_hresp_o),
      .FAULT_ADDR(s_faddr), .FAULT_CNT(s_fcnt), .FAULT_IRQ(s_firq));

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [7:0]  hsel;
      logic [7:0]  hsel_en;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        ready;
      logic        resp;
   } exp_t;

   vec_t  vecs[11];
   exp_t  exp_q[$];
   exp_t  e;
   int    checks   = 0;
   int    failures = 0;
   int    exp_cnt  = 0;
   int    exp_sat  = 0;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t);
      haddr  = a;
      htrans = t;
      @(negedge hclk);
   endtask

   task automatic check_resp(input string name, input logic rdy, input logic rsp);
      check({name, "_hready"}, 32'(m_hready), 32'(rdy));
      check({name, "_hresp"},  32'(m_hresp),  32'(rsp));
   endtask

   initial begin
      vecs[0]  = '{32'h0000_1234, T_NONSEQ, 8'h01, 8'h01, 32'hC0DE_0000};
      vecs[1]  = '{32'h2000_0010, T_NONSEQ, 8'h02, 8'h02, 32'hC0DE_0001};
      vecs[2]  = '{32'h2000_FFFC, T_SEQ,    8'h02, 8'h02, 32'hC0DE_0001};
      vecs[3]  = '{32'h3000_0000, T_NONSEQ, 8'h04, 8'h08, 32'hC0DE_0002};
      vecs[4]  = '{32'h4000_0040, T_NONSEQ, 8'h10, 8'h10, 32'hC0DE_0004};
      vecs[5]  = '{32'h5000_0000, T_NONSEQ, 8'h20, 8'h20, 32'hC0DE_0005};
      vecs[6]  = '{32'h8000_0000, T_SEQ,    8'h40, 8'h40, 32'hC0DE_0006};
      vecs[7]  = '{32'h9000_FFFF, T_NONSEQ, 8'h80, 8'h80, 32'hC0DE_0007};
      vecs[8]  = '{32'h6000_0000, T_IDLE,   8'h00, 8'h00, 32'h0000_0000};
      vecs[9]  = '{32'h2001_0000, T_BUSY,   8'h00, 8'h00, 32'h0000_0000};
      vecs[10] = '{32'h3000_0004, T_IDLE,   8'h04, 8'h08, 32'hC0DE_0002};

      for (int i = 0; i < 8; i++) s_hrdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
      s_hreadyout = 8'hFF;
      s_hresp     = 8'h00;
      hreset      = 1'b1;
      haddr       = 32'h6000_0000;
      htrans      = T_IDLE;

      // Reset: two cycles, then idle.
      repeat (2) @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      check_resp("reset", 1'b1, 1'b0);
      check("reset_hrdata", m_hrdata, 32'h0);
      check("reset_fcnt", 32'(m_fcnt), 32'h0);
      check("reset_faddr", m_faddr, 32'h0);
      check("reset_firq", 32'(m_firq), 32'h0);
      next_cycle();

      // Table: decode in the address phase, scoreboard compares the following data phase.
      for (int k = 0; k < 11; k++) begin
         drive(vecs[k].addr, vecs[k].trans);
         check($sformatf("hsel_%0d", k), 32'(m_hsel), 32'(vecs[k].hsel));
         check($sformatf("hsel_en_%0d", k), 32'(e_hsel), 32'(vecs[k].hsel_en));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("dp_rdata_%0d", k), m_hrdata, e.rdata);
            check($sformatf("dp_hready_%0d", k), 32'(m_hready), 32'(e.ready));
            check($sformatf("dp_hresp_%0d", k), 32'(m_hresp), 32'(e.resp));
         end
         exp_q.push_back('{vecs[k].rdata, 1'b1, 1'b0});
         next_cycle();
      end
      drive(32'h6000_0000, T_IDLE);
      e = exp_q.pop_front();
      check("dp_rdata_last", m_hrdata, e.rdata);
      check("dp_hready_last", 32'(m_hready), 32'(e.ready));
      check("dp_hresp_last", 32'(m_hresp), 32'(e.resp));
      check("idle_busy_no_fault", 32'(m_fcnt), 32'h0);
      next_cycle();

      // Mapped read on port 1 with one wait state.
      drive(32'h2000_0010, T_NONSEQ);
      check("wait_hsel", 32'(m_hsel), 32'h02);
      next_cycle();
      s_hreadyout[1] = 1'b0;
      s_hrdata[63:32] = 32'hDEAD_BEEF;
      drive(32'h0000_0000, T_IDLE);
      check_resp("wait_stall", 1'b0, 1'b0);
      next_cycle();
      s_hreadyout[1] = 1'b1;
      drive(32'h0000_0000, T_IDLE);
      check_resp("wait_done", 1'b1, 1'b0);
      check("wait_hrdata", m_hrdata, 32'hDEAD_BEEF);
      next_cycle();
      s_hrdata[63:32] = 32'hC0DE_0001;

      // Single unmapped NONSEQ: ERROR pair and fault capture.
      drive(32'h6000_0000, T_NONSEQ);
      check("unm_hsel", 32'(m_hsel), 32'h0);
      check("unm_irq_before", 32'(m_firq), 32'h0);
      next_cycle();
      exp_cnt = 1;
      drive(32'h0000_0000, T_IDLE);
      check_resp("unm_err1", 1'b0, 1'b1);
      check("unm_err1_hrdata", m_hrdata, 32'h0);
      check("unm_irq", 32'(m_firq), 32'h1);
      check("unm_faddr", m_faddr, 32'h6000_0000);
      check("unm_fcnt", 32'(m_fcnt), 32'(exp_cnt));
      next_cycle();
      drive(32'h0000_0000, T_IDLE);
      check_resp("unm_err2", 1'b1, 1'b1);
      check("unm_irq_after", 32'(m_firq), 32'h0);
      next_cycle();
      drive(32'h0000_0000, T_IDLE);
      check_resp("unm_done", 1'b1, 1'b0);
      next_cycle();

      // Back-to-back: unmapped NONSEQ during ERR2, then a port-4 NONSEQ during the second ERR2.
      drive(32'h6000_0100, T_NONSEQ);
      next_cycle();
      drive(32'h0000_0000, T_IDLE);
      check_resp("b2b_err1a", 1'b0, 1'b1);
      next_cycle();
      drive(32'h7000_0000, T_NONSEQ);
      check_resp("b2b_err2a", 1'b1, 1'b1);
      next_cycle();
      exp_cnt = 3;
      drive(32'h0000_0000, T_IDLE);
      check_resp("b2b_err1b", 1'b0, 1'b1);
      check("b2b_irq", 32'(m_firq), 32'h1);
      check("b2b_faddr", m_faddr, 32'h7000_0000);
      next_cycle();
      drive(32'h4000_0000, T_NONSEQ);
      check_resp("b2b_err2b", 1'b1, 1'b1);
      check("b2b_hsel4", 32'(m_hsel), 32'h10);
      next_cycle();
      drive(32'h0000_0000, T_IDLE);
      check_resp("b2b_port4", 1'b1, 1'b0);
      check("b2b_port4_hrdata", m_hrdata, 32'hC0DE_0004);
      check("b2b_fcnt", 32'(m_fcnt), 32'(exp_cnt));
      next_cycle();

      // Reset asserted while the default slave sits in ERR1.
      drive(32'h6000_0200, T_NONSEQ);
      next_cycle();
      hreset = 1'b1;
      drive(32'h6000_0000, T_IDLE);
      check_resp("rst_err1_before", 1'b0, 1'b1);
      next_cycle();
      hreset = 1'b0;
      drive(32'h6000_0000, T_IDLE);
      check_resp("rst_err1_after", 1'b1, 1'b0);
      check("rst_err1_fcnt", 32'(m_fcnt), 32'h0);
      check("rst_err1_faddr", m_faddr, 32'h0);
      check("rst_err1_irq", 32'(m_firq), 32'h0);
      next_cycle();

      // Five faults: 8-bit counter reaches 5, 2-bit counter saturates at 3.
      exp_cnt = 0;
      exp_sat = 0;
      for (int k = 1; k <= 5; k++) begin
         drive(32'h6000_0000 + 32'(k), T_NONSEQ);
         next_cycle();
         exp_cnt++;
         if (exp_sat < 3) exp_sat++;
         drive(32'h6000_0000, T_IDLE);
         check($sformatf("sat_err1_%0d", k), 32'(s_hready), 32'h0);
         next_cycle();
         drive(32'h6000_0000, T_IDLE);
         check($sformatf("sat_err2_resp_%0d", k), 32'(s_hresp_o), 32'h1);
         check($sformatf("sat_cnt_main_%0d", k), 32'(m_fcnt), 32'(exp_cnt));
         check($sformatf("sat_cnt_2b_%0d", k), 32'(s_fcnt), 32'(exp_sat));
         check($sformatf("sat_faddr_%0d", k), s_faddr, 32'h6000_0000 + 32'(k));
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
